// File: rtl/gfx_pixel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : gfx_pixel_addr_gen
// Purpose  : Three-stage pipelined (x,y) -> byte address, lane select,
//            split and clip flag generator for 8/16/24/32 bpp targets.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_pixel_addr_gen #(
    parameter int POINT_W      = 16,
    parameter int ADDR_W       = 32,
    parameter int BUS_BYTES    = 4,
    parameter int TAG_W        = 8,
    parameter int DROP_CLIPPED = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    cfg_base_i,
    input  logic [POINT_W-1:0]   cfg_width_i,
    input  logic [1:0]           cfg_depth_i,
    input  logic                 clip_en_i,
    input  logic [POINT_W-1:0]   clip_x0_i,
    input  logic [POINT_W-1:0]   clip_y0_i,
    input  logic [POINT_W-1:0]   clip_x1_i,
    input  logic [POINT_W-1:0]   clip_y1_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [POINT_W-1:0]   in_x_i,
    input  logic [POINT_W-1:0]   in_y_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ADDR_W-1:0]    out_addr_o,
    output logic [BUS_BYTES-1:0] out_sel_o,
    output logic                 out_split_o,
    output logic                 out_clipped_o,
    output logic [TAG_W-1:0]     out_tag_o,
    output logic                 busy_o
);

    localparam int          c_LANE_W    = $clog2(BUS_BYTES);
    localparam int          c_MASK_W    = 2 * BUS_BYTES;
    localparam logic [3:0]  c_BUS_BYTES = BUS_BYTES[3:0];

    // ------------------------------------------------------------------
    // Input-side arithmetic: sign-extend coordinates, y*width, clip test
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_xs;
    logic [ADDR_W-1:0] w_ys;
    logic [ADDR_W-1:0] w_wz;
    logic [ADDR_W-1:0] w_prod;
    logic              w_inside;
    logic              w_clip;
    logic              w_keep;

    assign w_xs   = {{(ADDR_W-POINT_W){in_x_i[POINT_W-1]}}, in_x_i};
    assign w_ys   = {{(ADDR_W-POINT_W){in_y_i[POINT_W-1]}}, in_y_i};
    assign w_wz   = {{(ADDR_W-POINT_W){1'b0}}, cfg_width_i};
    // Truncated product of two's complement operands is exact modulo 2^ADDR_W
    assign w_prod = w_ys * w_wz;

    assign w_inside = ($signed(in_x_i) >= $signed(clip_x0_i)) &&
                      ($signed(in_x_i) <= $signed(clip_x1_i)) &&
                      ($signed(in_y_i) >= $signed(clip_y0_i)) &&
                      ($signed(in_y_i) <= $signed(clip_y1_i));
    assign w_clip   = clip_en_i && !w_inside;
    // A dropped pixel is still handshaken but never occupies the pipeline
    assign w_keep   = !((DROP_CLIPPED != 0) && w_clip);

    // ------------------------------------------------------------------
    // Pipeline control: a stage may load when it is empty or draining
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_rdy1, w_rdy2, w_rdy3;

    assign w_rdy3     = !r_v3 || out_ready_i;
    assign w_rdy2     = !r_v2 || w_rdy3;
    assign w_rdy1     = !r_v1 || w_rdy2;
    assign in_ready_o = w_rdy1;
    assign busy_o     = r_v1 || r_v2 || r_v3;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r1_prod;
    logic [ADDR_W-1:0] r1_xs;
    logic [ADDR_W-1:0] r1_base;
    logic [1:0]        r1_depth;
    logic              r1_clip;
    logic [TAG_W-1:0]  r1_tag;

    // Stage 1: capture pixel with its configuration snapshot and clip result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1     <= 1'b0;
            r1_prod  <= '0;
            r1_xs    <= '0;
            r1_base  <= '0;
            r1_depth <= '0;
            r1_clip  <= 1'b0;
            r1_tag   <= '0;
        end else if (w_rdy1) begin
            r_v1     <= in_valid_i && w_keep;
            r1_prod  <= w_prod;
            r1_xs    <= w_xs;
            r1_base  <= cfg_base_i;
            r1_depth <= cfg_depth_i;
            r1_clip  <= w_clip;
            r1_tag   <= in_tag_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r2_offs;
    logic [ADDR_W-1:0] r2_base;
    logic [1:0]        r2_depth;
    logic              r2_clip;
    logic [TAG_W-1:0]  r2_tag;

    // Stage 2: pixel offset = y*width + x
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v2     <= 1'b0;
            r2_offs  <= '0;
            r2_base  <= '0;
            r2_depth <= '0;
            r2_clip  <= 1'b0;
            r2_tag   <= '0;
        end else if (w_rdy2) begin
            r_v2     <= r_v1;
            r2_offs  <= r1_prod + r1_xs;
            r2_base  <= r1_base;
            r2_depth <= r1_depth;
            r2_clip  <= r1_clip;
            r2_tag   <= r1_tag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 combinational: scale by bytes per pixel, lane and split
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]   w_scaled;
    logic [ADDR_W-1:0]   w_addr;
    logic [c_LANE_W-1:0] w_lane;
    logic [2:0]          w_bpp;
    logic [c_MASK_W-1:0] w_mask;
    logic [c_MASK_W-1:0] w_mask_sh;
    logic [3:0]          w_lane_ext;
    logic [3:0]          w_sum;
    logic                w_split;

    // Byte scaling and the unshifted lane mask for the pixel depth
    always_comb begin
        w_scaled = r2_offs;
        w_mask   = '0;
        case (r2_depth)
            2'd0: begin
                w_scaled    = r2_offs;
                w_mask[3:0] = 4'b0001;
            end
            2'd1: begin
                w_scaled    = r2_offs << 1;
                w_mask[3:0] = 4'b0011;
            end
            2'd2: begin
                w_scaled    = (r2_offs << 1) + r2_offs;
                w_mask[3:0] = 4'b0111;
            end
            default: begin
                w_scaled    = r2_offs << 2;
                w_mask[3:0] = 4'b1111;
            end
        endcase
    end

    assign w_bpp      = {1'b0, r2_depth} + 3'd1;
    assign w_addr     = r2_base + w_scaled;
    assign w_lane     = w_addr[c_LANE_W-1:0];
    assign w_mask_sh  = w_mask << w_lane;
    assign w_lane_ext = {{(4-c_LANE_W){1'b0}}, w_lane};
    assign w_sum      = w_lane_ext + {1'b0, w_bpp};
    assign w_split    = (w_sum > c_BUS_BYTES);

    // Stage 3: registered outputs, held while the consumer stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v3          <= 1'b0;
            out_addr_o    <= '0;
            out_sel_o     <= '0;
            out_split_o   <= 1'b0;
            out_clipped_o <= 1'b0;
            out_tag_o     <= '0;
        end else if (w_rdy3) begin
            r_v3          <= r_v2;
            out_addr_o    <= w_addr;
            out_sel_o     <= w_mask_sh[BUS_BYTES-1:0];
            out_split_o   <= w_split;
            out_clipped_o <= r2_clip;
            out_tag_o     <= r2_tag;
        end
    end

    assign out_valid_o = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_gfx_pixel_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_pixel_addr_gen
// Purpose  : Directed self-checking bench for gfx_pixel_addr_gen, with a
//            dropping instance and a flag-passing instance side by side.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gfx_pixel_addr_gen;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        split;
        logic        clip;
        logic [7:0]  tag;
        int          cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_base = '0;
    logic [15:0] cfg_width = 16'd640;
    logic [1:0]  cfg_depth = 2'd3;
    logic        clip_en = 1'b0;
    logic [15:0] clip_x0 = '0, clip_y0 = '0, clip_x1 = '0, clip_y1 = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_x = '0, in_y = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_split, out_clipped, busy;
    logic [31:0] out_addr;
    logic [3:0]  out_sel;
    logic [7:0]  out_tag;

    logic        in_ready_n, out_valid_n, out_split_n, out_clipped_n, busy_n;
    logic [31:0] out_addr_n;
    logic [3:0]  out_sel_n;
    logic [7:0]  out_tag_n;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   rnd_en = 1'b0;
    bit   hold_en = 1'b1;
    bit   stall_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_tag = '0;
    rec_t q_d[$];
    rec_t q_n[$];

    gfx_pixel_addr_gen #(.DROP_CLIPPED(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_base_i(cfg_base), .cfg_width_i(cfg_width), .cfg_depth_i(cfg_depth),
        .clip_en_i(clip_en), .clip_x0_i(clip_x0), .clip_y0_i(clip_y0),
        .clip_x1_i(clip_x1), .clip_y1_i(clip_y1),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_x_i(in_x), .in_y_i(in_y), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_sel_o(out_sel), .out_split_o(out_split),
        .out_clipped_o(out_clipped), .out_tag_o(out_tag), .busy_o(busy)
    );

    gfx_pixel_addr_gen #(.DROP_CLIPPED(0)) u_dut_nd (
        .clk_i(clk), .rst_i(rst),
        .cfg_base_i(cfg_base), .cfg_width_i(cfg_width), .cfg_depth_i(cfg_depth),
        .clip_en_i(clip_en), .clip_x0_i(clip_x0), .clip_y0_i(clip_y0),
        .clip_x1_i(clip_x1), .clip_y1_i(clip_y1),
        .in_valid_i(in_valid), .in_ready_o(in_ready_n),
        .in_x_i(in_x), .in_y_i(in_y), .in_tag_i(in_tag),
        .out_valid_o(out_valid_n), .out_ready_i(out_ready),
        .out_addr_o(out_addr_n), .out_sel_o(out_sel_n), .out_split_o(out_split_n),
        .out_clipped_o(out_clipped_n), .out_tag_o(out_tag_n), .busy_o(busy_n)
    );

    always #5 clk = ~clk;

    // Cycle counter for throughput measurement
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Random backpressure, changed just after the active edge
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 1) == 1);
    end

    // Output monitor: stall stability and capture of accepted results
    initial forever begin
        rec_t r;
        @(negedge clk);
        if (hold_en && stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_addr", 64'(out_addr), 64'(prev_addr));
            chk("hold_tag", 64'(out_tag), 64'(prev_tag));
        end
        stall_prev = out_valid && !out_ready;
        prev_addr  = out_addr;
        prev_tag   = out_tag;
        if (!rst && out_valid && out_ready) begin
            r.addr = out_addr; r.sel = out_sel; r.split = out_split;
            r.clip = out_clipped; r.tag = out_tag; r.cyc = cyc;
            q_d.push_back(r);
        end
        if (!rst && out_valid_n && out_ready) begin
            r.addr = out_addr_n; r.sel = out_sel_n; r.split = out_split_n;
            r.clip = out_clipped_n; r.tag = out_tag_n; r.cyc = cyc;
            q_n.push_back(r);
        end
    end

    // Present one pixel at a negedge and hold it until accepted
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [7:0] tag);
        int n = 0;
        in_valid = 1'b1; in_x = x; in_y = y; in_tag = tag;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        int k = 0;
        while (q_d.size() < n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(q_d.size()), 64'(n));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_sel", 64'(out_sel), 64'd0);

        // 32bpp, latency of three edges from acceptance
        cfg_base = 32'h1000; cfg_width = 16'd640; cfg_depth = 2'd3;
        send(16'd3, 16'd2, 8'h11);
        chk("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_c3", 64'(out_valid), 64'd1);
        chk("t1_addr", 64'(out_addr), 64'h240C);
        chk("t1_sel", 64'(out_sel), 64'hF);
        chk("t1_split", 64'(out_split), 64'd0);
        chk("t1_tag", 64'(out_tag), 64'h11);
        repeat (3) @(negedge clk);
        q_d.delete(); q_n.delete();

        // 24bpp lane and split
        cfg_base = 32'h0; cfg_depth = 2'd2;
        send(16'd1, 16'd0, 8'h21);
        send(16'd4, 16'd0, 8'h22);
        wait_q(2, "t2_count");
        if (q_d.size() >= 2) begin
            chk("t2a_addr", 64'(q_d[0].addr), 64'd3);
            chk("t2a_sel", 64'(q_d[0].sel), 64'b1000);
            chk("t2a_split", 64'(q_d[0].split), 64'd1);
            chk("t2b_addr", 64'(q_d[1].addr), 64'd12);
            chk("t2b_sel", 64'(q_d[1].sel), 64'b0111);
            chk("t2b_split", 64'(q_d[1].split), 64'd0);
        end
        repeat (3) @(negedge clk);
        q_d.delete(); q_n.delete();

        // Clipping: drop vs. pass-with-flag
        cfg_depth = 2'd3; clip_en = 1'b1;
        clip_x0 = 16'd0; clip_y0 = 16'd0; clip_x1 = 16'd9; clip_y1 = 16'd9;
        send(16'hFFFF, 16'd5, 8'hA0);
        send(16'd0, 16'd5, 8'hA1);
        send(16'd9, 16'd5, 8'hA2);
        send(16'd10, 16'd5, 8'hA3);
        wait_q(2, "t3_count");
        repeat (6) @(negedge clk);
        chk("t3_drop_n", 64'(q_d.size()), 64'd2);
        chk("t3_pass_n", 64'(q_n.size()), 64'd4);
        if (q_d.size() >= 2) begin
            chk("t3_tag0", 64'(q_d[0].tag), 64'hA1);
            chk("t3_tag1", 64'(q_d[1].tag), 64'hA2);
        end
        if (q_n.size() >= 4) begin
            chk("t3_clip0", 64'(q_n[0].clip), 64'd1);
            chk("t3_clip1", 64'(q_n[1].clip), 64'd0);
            chk("t3_clip2", 64'(q_n[2].clip), 64'd0);
            chk("t3_clip3", 64'(q_n[3].clip), 64'd1);
            chk("t3_ntag3", 64'(q_n[3].tag), 64'hA3);
        end
        clip_en = 1'b0;
        q_d.delete(); q_n.delete();

        // 100 pixels under random backpressure
        cfg_base = 32'h0; cfg_width = 16'd640; cfg_depth = 2'd3;
        rnd_en = 1'b1;
        for (int i = 0; i < 100; i++) send(16'(i), 16'd1, 8'(i));
        wait_q(100, "t4_count");
        rnd_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && i < q_d.size(); i++) begin
            chk("t4_tag", 64'(q_d[i].tag), 64'(i));
            chk("t4_addr", 64'(q_d[i].addr), 64'(4 * (640 + i)));
        end
        repeat (4) @(negedge clk);
        q_d.delete(); q_n.delete();

        // Full throughput with no backpressure
        for (int i = 0; i < 20; i++) send(16'(i), 16'd0, 8'(i));
        wait_q(20, "thru_count");
        if (q_d.size() >= 20) chk("thru_span", 64'(q_d[19].cyc - q_d[0].cyc), 64'd19);
        repeat (4) @(negedge clk);
        q_d.delete(); q_n.delete();

        // Depth is snapshotted at acceptance
        cfg_base = 32'h100; cfg_width = 16'd10; cfg_depth = 2'd1;
        send(16'd5, 16'd1, 8'h55);
        cfg_depth = 2'd0;
        wait_q(1, "t5_count");
        if (q_d.size() >= 1) begin
            chk("t5_addr", 64'(q_d[0].addr), 64'h11E);
            chk("t5_sel", 64'(q_d[0].sel), 64'b1100);
            chk("t5_split", 64'(q_d[0].split), 64'd0);
        end
        repeat (4) @(negedge clk);
        q_d.delete(); q_n.delete();

        // Reset with three pixels in flight
        hold_en = 1'b0;
        out_ready = 1'b0;
        send(16'd1, 16'd1, 8'h61);
        send(16'd2, 16'd1, 8'h62);
        send(16'd3, 16'd1, 8'h63);
        chk("t6_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ready", 64'(in_ready), 64'd1);
        chk("t6_addr", 64'(out_addr), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_stale_d", 64'(q_d.size()), 64'd0);
        chk("t6_stale_n", 64'(q_n.size()), 64'd0);
        hold_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
